// File: rtl/asi_poll_scheduler_pkg.sv
// Shared definitions for the ASI master poll scheduler: state encoding,
// ASI response frame field positions, default timing and an address picker.
package asi_poll_scheduler_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CODE_W = 7;
    localparam int unsigned MASK_W = 31;
    localparam int unsigned TMO_W  = 11;

    // Decoded slave response frame layout: start, I3..I0, parity, end
    localparam int unsigned CODE_START_BIT  = 6;
    localparam int unsigned CODE_DATA_MSB   = 5;
    localparam int unsigned CODE_DATA_LSB   = 2;
    localparam int unsigned CODE_PARITY_BIT = 1;
    localparam int unsigned CODE_END_BIT    = 0;

    // Default timing at a 12 MHz clk_in
    localparam int unsigned RESP_TIMEOUT_DEF = 1200;
    localparam int unsigned PAUSE_LEN_DEF    = 24;
    localparam int unsigned MAX_RETRY_DEF    = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_CHECK   = 3'd4,
        ST_PAUSE   = 3'd5,
        ST_NEXT    = 3'd6
    } poll_state_e;

    typedef struct packed {
        logic              found;
        logic [ADDR_W-1:0] addr;
    } addr_pick_t;

    // Lowest enabled slave address strictly above 'from' (from = 0 gives the lowest overall)
    function automatic addr_pick_t next_enabled(input logic [MASK_W-1:0] mask,
                                                input logic [ADDR_W-1:0] from);
        addr_pick_t pick;
        pick = '0;
        for (int n = MASK_W; n >= 1; n--) begin
            if ((n > int'(from)) && mask[ADDR_W'(n - 1)]) begin
                pick.found = 1'b1;
                pick.addr  = ADDR_W'(n);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/asi_resp_check.sv
// Combinational validity check of a decoded ASI slave response frame.
module asi_resp_check
    import asi_poll_scheduler_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic              frame_ok_c,
    output logic [DATA_W-1:0] data_c
);

    // Valid frame: start bit low, end bit high, parity bit makes the data ones-count even
    always_comb begin
        data_c     = code[CODE_DATA_MSB:CODE_DATA_LSB];
        frame_ok_c = !code[CODE_START_BIT]
                   && code[CODE_END_BIT]
                   && (code[CODE_PARITY_BIT] == (^code[CODE_DATA_MSB:CODE_DATA_LSB]));
    end

endmodule

// File: rtl/asi_poll_scheduler.sv
// ASI master poll scheduler: walks the enabled slave addresses once per start,
// sends each a request, waits for a checked response with timeout and retries,
// and reports per-slave data or failure plus an end-of-cycle pulse.
module asi_poll_scheduler
    import asi_poll_scheduler_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = RESP_TIMEOUT_DEF,
    parameter int unsigned PAUSE_LEN    = PAUSE_LEN_DEF,
    parameter int unsigned MAX_RETRY    = MAX_RETRY_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              start,
    input  logic [MASK_W-1:0] slave_en,
    input  logic [DATA_W-1:0] out_data,
    output logic              tx_req,
    output logic [ADDR_W-1:0] tx_addr,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    input  logic              decoding_flag,
    input  logic [CODE_W-1:0] code,
    output logic              rx_valid,
    output logic [ADDR_W-1:0] rx_addr,
    output logic [DATA_W-1:0] rx_data,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
    output logic              cycle_done,
    output logic              busy
);

    localparam int unsigned PAUSE_W = (PAUSE_LEN > 1) ? $clog2(PAUSE_LEN) : 1;
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
    localparam int unsigned TMO_MAX = (1 << TMO_W) - 1;

    localparam logic [TMO_W-1:0]   TMO_LIMIT  = TMO_W'((RESP_TIMEOUT > TMO_MAX) ? TMO_MAX : RESP_TIMEOUT);
    localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'((PAUSE_LEN > 0) ? (PAUSE_LEN - 1) : 0);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    poll_state_e        state;
    logic [MASK_W-1:0]  mask_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [RETRY_W-1:0] retry_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [PAUSE_W-1:0] pause_cnt;
    logic               resume_next;
    logic               tx_busy_q;
    logic               dec_q;

    logic               resp_ok_c;
    logic [DATA_W-1:0]  resp_data_c;
    logic               dec_rise_c;
    logic               tx_fall_c;
    logic               retry_left_c;
    addr_pick_t         idle_pick_c;
    addr_pick_t         next_pick_c;

    asi_resp_check u_resp_check (
        .code       (code),
        .frame_ok_c (resp_ok_c),
        .data_c     (resp_data_c)
    );

    // Edge detects, retry budget and address selection for the sequencer
    always_comb begin
        dec_rise_c   = decoding_flag & ~dec_q;
        tx_fall_c    = tx_busy_q & ~tx_busy;
        retry_left_c = (retry_q < RETRY_MAX);
        idle_pick_c  = next_enabled(slave_en, ADDR_W'(0));
        next_pick_c  = next_enabled(mask_q, addr_q);
    end

    // Poll sequencer with registered request/response/error/done outputs
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            mask_q      <= '0;
            addr_q      <= '0;
            retry_q     <= '0;
            tmo_cnt     <= '0;
            pause_cnt   <= '0;
            resume_next <= 1'b0;
            tx_busy_q   <= 1'b0;
            dec_q       <= 1'b0;
            tx_req      <= 1'b0;
            tx_addr     <= '0;
            tx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_addr     <= '0;
            rx_data     <= '0;
            err_valid   <= 1'b0;
            err_addr    <= '0;
            cycle_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_req     <= 1'b0;
            rx_valid   <= 1'b0;
            err_valid  <= 1'b0;
            cycle_done <= 1'b0;
            tx_busy_q  <= tx_busy;
            dec_q      <= decoding_flag;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (idle_pick_c.found) begin
                            mask_q  <= slave_en;
                            addr_q  <= idle_pick_c.addr;
                            retry_q <= '0;
                            busy    <= 1'b1;
                            state   <= ST_SEND;
                        end else begin
                            cycle_done <= 1'b1;
                        end
                    end
                end

                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_req  <= 1'b1;
                        tx_addr <= addr_q;
                        tx_data <= out_data;
                        state   <= ST_WAIT_TX;
                    end
                end

                ST_WAIT_TX: begin
                    if (tx_fall_c) begin
                        tmo_cnt <= '0;
                        state   <= ST_WAIT_RX;
                    end
                end

                ST_WAIT_RX: begin
                    // A response edge wins over a coincident timeout
                    if (dec_rise_c) begin
                        state <= ST_CHECK;
                    end else if (tmo_cnt == TMO_LIMIT) begin
                        if (retry_left_c) begin
                            retry_q     <= retry_q + RETRY_W'(1);
                            resume_next <= 1'b0;
                        end else begin
                            err_valid   <= 1'b1;
                            err_addr    <= addr_q;
                            resume_next <= 1'b1;
                        end
                        pause_cnt <= '0;
                        state     <= ST_PAUSE;
                    end else if (tmo_cnt != TMO_W'(TMO_MAX)) begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                ST_CHECK: begin
                    if (resp_ok_c) begin
                        rx_valid    <= 1'b1;
                        rx_addr     <= addr_q;
                        rx_data     <= resp_data_c;
                        resume_next <= 1'b1;
                    end else if (retry_left_c) begin
                        retry_q     <= retry_q + RETRY_W'(1);
                        resume_next <= 1'b0;
                    end else begin
                        err_valid   <= 1'b1;
                        err_addr    <= addr_q;
                        resume_next <= 1'b1;
                    end
                    pause_cnt <= '0;
                    state     <= ST_PAUSE;
                end

                ST_PAUSE: begin
                    if (pause_cnt == PAUSE_LAST) begin
                        state <= resume_next ? ST_NEXT : ST_SEND;
                    end else begin
                        pause_cnt <= pause_cnt + PAUSE_W'(1);
                    end
                end

                ST_NEXT: begin
                    if (next_pick_c.found) begin
                        addr_q  <= next_pick_c.addr;
                        retry_q <= '0;
                        state   <= ST_SEND;
                    end else begin
                        cycle_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_asi_poll_scheduler.sv
// Randomized bench for asi_poll_scheduler with encoder/slave models and a
// poll-cycle reference model derived from the addressing and retry rules.
module tb_asi_poll_scheduler;

    localparam int unsigned RT = 1200;
    localparam int unsigned PL = 24;
    localparam int unsigned MR = 2;

    typedef struct {
        int kind;
        int addr;
        int data;
    } ev_t;

    logic        clk_in = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [30:0] slave_en = '0;
    logic [3:0]  out_data = '0;
    logic        tx_busy = 1'b0;
    logic        decoding_flag = 1'b0;
    logic [6:0]  code = '0;
    logic        tx_req;
    logic [4:0]  tx_addr;
    logic [3:0]  tx_data;
    logic        rx_valid;
    logic [4:0]  rx_addr;
    logic [3:0]  rx_data;
    logic        err_valid;
    logic [4:0]  err_addr;
    logic        cycle_done;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Per (address, attempt) slave behaviour: 0 good, 1 bad parity, 2 start bit set, 3 silent, 4 end bit low
    int       outc [32][MR+1];
    logic [3:0] dat [32][MR+1];
    int       req_cnt [32];

    ev_t exp_ev[$];
    int  exp_tx[$];
    ev_t got_ev[$];
    int  got_tx[$];
    int  tx_cyc[$];
    int  done_cnt = 0;

    asi_poll_scheduler #(
        .RESP_TIMEOUT (RT),
        .PAUSE_LEN    (PL),
        .MAX_RETRY    (MR)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .start         (start),
        .slave_en      (slave_en),
        .out_data      (out_data),
        .tx_req        (tx_req),
        .tx_addr       (tx_addr),
        .tx_data       (tx_data),
        .tx_busy       (tx_busy),
        .decoding_flag (decoding_flag),
        .code          (code),
        .rx_valid      (rx_valid),
        .rx_addr       (rx_addr),
        .rx_data       (rx_data),
        .err_valid     (err_valid),
        .err_addr      (err_addr),
        .cycle_done    (cycle_done),
        .busy          (busy)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [6:0] make_code(input int o, input logic [3:0] d);
        case (o)
            0:       return {1'b0, d, ^d, 1'b1};
            1:       return {1'b0, d, ~(^d), 1'b1};
            2:       return {1'b1, d, ^d, 1'b1};
            default: return {1'b0, d, ^d, 1'b0};
        endcase
    endfunction

    // Encoder and slave models
    int   enc_left = 0;
    int   resp_left = 0;
    int   hold_left = 0;
    bit   pending = 0;
    int   cur_addr = 0;
    int   cur_att = 0;
    always @(negedge clk_in) begin
        if (!rst) begin
            tx_busy = 1'b0;
            decoding_flag = 1'b0;
            enc_left = 0;
            resp_left = 0;
            hold_left = 0;
            pending = 0;
        end else begin
            if (tx_req) begin
                cur_addr = int'(tx_addr);
                cur_att = (req_cnt[cur_addr] > int'(MR)) ? int'(MR) : req_cnt[cur_addr];
                req_cnt[cur_addr]++;
                enc_left = $urandom_range(3, 12);
                tx_busy = 1'b1;
            end else if (enc_left > 0) begin
                enc_left--;
                if (enc_left == 0) begin
                    tx_busy = 1'b0;
                    if (outc[cur_addr][cur_att] != 3) begin
                        pending = 1;
                        resp_left = $urandom_range(3, 40);
                    end
                end
            end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) decoding_flag = 1'b0;
            end else if (pending) begin
                resp_left--;
                if (resp_left == 0) begin
                    pending = 0;
                    code = make_code(outc[cur_addr][cur_att], dat[cur_addr][cur_att]);
                    decoding_flag = 1'b1;
                    hold_left = 3;
                end
            end
        end
    end

    // Output monitor
    always @(negedge clk_in) begin
        if (rst) begin
            if (tx_req) begin
                got_tx.push_back(int'(tx_addr));
                tx_cyc.push_back(cyc);
                total++;
                if (tx_data !== out_data) begin
                    bad++;
                    $display("FAIL tx_data: got=%h exp=%h", tx_data, out_data);
                end
            end
            if (rx_valid) got_ev.push_back('{0, int'(rx_addr), int'(rx_data)});
            if (err_valid) got_ev.push_back('{1, int'(err_addr), 0});
            if (cycle_done) done_cnt++;
            if (rx_valid || err_valid || cycle_done) begin
                total++;
                if ((int'(rx_valid) + int'(err_valid) + int'(cycle_done)) > 1) begin
                    bad++;
                    $display("FAIL exclusive_pulses: rx=%b err=%b done=%b exp at most one",
                             rx_valid, err_valid, cycle_done);
                end
            end
        end
    end

    task automatic plan_good();
        for (int a = 0; a < 32; a++)
            for (int t = 0; t <= int'(MR); t++) begin
                outc[a][t] = 0;
                dat[a][t] = 4'($urandom);
            end
    endtask

    task automatic plan_random();
        int r;
        for (int a = 0; a < 32; a++)
            for (int t = 0; t <= int'(MR); t++) begin
                r = $urandom_range(0, 15);
                outc[a][t] = (r < 10) ? 0 : (r < 12) ? 1 : (r == 12) ? 2 : (r == 13) ? 4 : 3;
                dat[a][t] = 4'($urandom);
            end
    endtask

    // Reference: ascending enabled addresses, up to MR retries, first good response reports data
    task automatic build_expected(input logic [30:0] mask);
        exp_ev.delete();
        exp_tx.delete();
        for (int a = 1; a <= 31; a++) begin
            if (mask[a-1]) begin
                for (int t = 0; t <= int'(MR); t++) begin
                    exp_tx.push_back(a);
                    if (outc[a][t] == 0) begin
                        exp_ev.push_back('{0, a, int'(dat[a][t])});
                        break;
                    end else if (t == int'(MR)) begin
                        exp_ev.push_back('{1, a, 0});
                    end
                end
            end
        end
    endtask

    task automatic clear_obs();
        got_ev.delete();
        got_tx.delete();
        tx_cyc.delete();
        done_cnt = 0;
        for (int a = 0; a < 32; a++) req_cnt[a] = 0;
    endtask

    task automatic check_outputs_zero(input string name);
        logic [31:0] all_out;
        all_out = {tx_req, tx_addr, tx_data, rx_valid, rx_addr, rx_data,
                   err_valid, err_addr, cycle_done, busy};
        total++;
        if (all_out !== 32'd0) begin
            bad++;
            $display("FAIL %s: outputs=%h exp=0", name, all_out);
        end
    endtask

    task automatic run_cycle(input string name, input logic [30:0] mask, input bit inject);
        bit timed_out;
        int k;
        build_expected(mask);
        clear_obs();
        out_data = 4'($urandom);
        k = $urandom_range(5, 25);
        @(posedge clk_in); #1;
        start = 1'b1;
        slave_en = mask;
        @(posedge clk_in); #1;
        start = 1'b0;
        slave_en = 31'($urandom);
        @(negedge clk_in);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL %s busy_after_start: got=%b exp=1", name, busy);
        end
        timed_out = 1;
        for (int i = 0; i < 40000; i++) begin
            @(posedge clk_in);
            if (done_cnt > 0) begin
                timed_out = 0;
                break;
            end
            #1;
            start = (inject && i == k) ? 1'b1 : 1'b0;
            if (inject && i == k) slave_en = 31'($urandom);
        end
        start = 1'b0;
        total++;
        if (timed_out) begin
            bad++;
            $display("FAIL %s timeout: no cycle_done within budget", name);
        end
        repeat (5) @(negedge clk_in);
        total++;
        if (got_tx.size() != exp_tx.size()) begin
            bad++;
            $display("FAIL %s tx_count: got=%0d exp=%0d", name, got_tx.size(), exp_tx.size());
        end
        for (int i = 0; i < exp_tx.size(); i++) begin
            total++;
            if (i >= got_tx.size() || got_tx[i] != exp_tx[i]) begin
                bad++;
                $display("FAIL %s tx_addr[%0d]: got=%0d exp=%0d", name, i,
                         (i < got_tx.size()) ? got_tx[i] : -1, exp_tx[i]);
            end
        end
        total++;
        if (got_ev.size() != exp_ev.size()) begin
            bad++;
            $display("FAIL %s event_count: got=%0d exp=%0d", name, got_ev.size(), exp_ev.size());
        end
        for (int i = 0; i < exp_ev.size(); i++) begin
            total++;
            if (i >= got_ev.size() || got_ev[i].kind != exp_ev[i].kind ||
                got_ev[i].addr != exp_ev[i].addr || got_ev[i].data != exp_ev[i].data) begin
                bad++;
                if (i < got_ev.size())
                    $display("FAIL %s event[%0d]: got=(%0d,%0d,%h) exp=(%0d,%0d,%h)", name, i,
                             got_ev[i].kind, got_ev[i].addr, got_ev[i].data,
                             exp_ev[i].kind, exp_ev[i].addr, exp_ev[i].data);
                else
                    $display("FAIL %s event[%0d]: got=none exp=(%0d,%0d,%h)", name, i,
                             exp_ev[i].kind, exp_ev[i].addr, exp_ev[i].data);
            end
        end
        total++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s end_state: done_cnt=%0d busy=%b exp done_cnt=1 busy=0",
                     name, done_cnt, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        check_outputs_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_two_slaves();
        plan_good();
        dat[1][0] = 4'hA;
        dat[3][0] = 4'h3;
        run_cycle("two_slaves", 31'h5, 0);
    endtask

    task automatic test_silent_slave();
        plan_good();
        for (int t = 0; t <= int'(MR); t++) outc[2][t] = 3;
        run_cycle("silent", 31'h2, 0);
        total++;
        if (tx_cyc.size() != 3) begin
            bad++;
            $display("FAIL silent request_count: got=%0d exp=3", tx_cyc.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (tx_cyc[i] - tx_cyc[i-1] < int'(RT + PL) ||
                    tx_cyc[i] - tx_cyc[i-1] > int'(RT + PL) + 30) begin
                    bad++;
                    $display("FAIL silent gap[%0d]: got=%0d exp=%0d..%0d", i,
                             tx_cyc[i] - tx_cyc[i-1], RT + PL, RT + PL + 30);
                end
            end
        end
    endtask

    task automatic test_parity_retry();
        plan_good();
        outc[4][0] = 1;
        run_cycle("parity_retry", 31'h8, 0);
    endtask

    task automatic test_empty_mask();
        clear_obs();
        @(posedge clk_in); #1;
        start = 1'b1;
        slave_en = '0;
        @(posedge clk_in); #1;
        start = 1'b0;
        @(negedge clk_in);
        total++;
        if (cycle_done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_mask done: cycle_done=%b busy=%b exp 1/0", cycle_done, busy);
        end
        repeat (10) @(negedge clk_in);
        total++;
        if (done_cnt != 1 || got_tx.size() != 0) begin
            bad++;
            $display("FAIL empty_mask after: done_cnt=%0d tx=%0d exp 1/0", done_cnt, got_tx.size());
        end
    endtask

    task automatic test_reset_mid_wait();
        bit reached;
        plan_good();
        for (int t = 0; t <= int'(MR); t++) outc[2][t] = 3;
        clear_obs();
        @(posedge clk_in); #1;
        start = 1'b1;
        slave_en = 31'h12;
        @(posedge clk_in); #1;
        start = 1'b0;
        reached = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (got_tx.size() > 0 && !tx_busy && enc_left == 0) begin
                reached = 1;
                break;
            end
        end
        total++;
        if (!reached) begin
            bad++;
            $display("FAIL reset_mid: request not seen within budget");
        end
        repeat (30) @(negedge clk_in);
        rst = 1'b0;
        #1;
        check_outputs_zero("reset_mid_wait");
        repeat (3) @(negedge clk_in);
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        total++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid no_done: done_cnt=%0d busy=%b exp 0/0", done_cnt, busy);
        end
        plan_good();
        run_cycle("after_reset", 31'h12, 0);
    endtask

    task automatic test_start_while_busy();
        plan_random();
        run_cycle("start_while_busy", 31'h4 | (31'($urandom) & 31'($urandom) & 31'($urandom)), 1);
    endtask

    task automatic test_random();
        logic [30:0] m;
        for (int n = 0; n < 6; n++) begin
            plan_random();
            m = 31'($urandom) & 31'($urandom) & 31'($urandom);
            if (m == '0) m = 31'h1 << $urandom_range(0, 30);
            run_cycle("random", m, 0);
        end
        plan_good();
        run_cycle("top_address", 31'h4000_0001, 0);
    endtask

    initial begin
        test_reset();
        test_two_slaves();
        test_silent_slave();
        test_parity_retry();
        test_empty_mask();
        test_reset_mid_wait();
        test_start_while_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
